// File: rtl/fp_special_case_sequencer_if.sv
// Handshake bundle between the FP special-case sequencer and its environment:
// operand intake, core dispatch/response and result delivery.
interface fp_special_case_sequencer_if #(
  parameter int num_bits = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [num_bits-1:0] in_a;
  logic [num_bits-1:0] in_b;
  logic                in_op;

  logic                core_valid;
  logic                core_ready;
  logic [num_bits-1:0] core_a;
  logic [num_bits-1:0] core_b;
  logic                core_op;
  logic                core_res_valid;
  logic [num_bits-1:0] core_res;

  logic                out_valid;
  logic                out_ready;
  logic [num_bits-1:0] out_res;
  logic                out_invalid;
  logic                out_timeout;

  // Sequencer side
  modport slave (
    input  in_valid, in_a, in_b, in_op,
    input  core_ready, core_res_valid, core_res,
    input  out_ready,
    output in_ready,
    output core_valid, core_a, core_b, core_op,
    output out_valid, out_res, out_invalid, out_timeout
  );

  // Environment side: operand source, FP core and result consumer
  modport master (
    output in_valid, in_a, in_b, in_op,
    output core_ready, core_res_valid, core_res,
    output out_ready,
    input  in_ready,
    input  core_valid, core_a, core_b, core_op,
    input  out_valid, out_res, out_invalid, out_timeout
  );
endinterface

// File: rtl/fp_special_case_sequencer.sv
// Resolves IEEE special operand pairs locally (accept->result in 2 cycles), otherwise dispatches to
// the FP core with a response watchdog; one transaction in flight, result held until out_ready.
module fp_special_case_sequencer #(
  parameter int num_bits       = 32,
  parameter int exp_width      = 8,
  parameter int mant_width     = 23,
  parameter int timeout_cycles = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  fp_special_case_sequencer_if.slave   bus
);

  if (num_bits != 1 + exp_width + mant_width) begin : g_bad_width
    $error("num_bits must equal 1 + exp_width + mant_width");
  end
  if (timeout_cycles < 2) begin : g_bad_timeout
    $error("timeout_cycles must be at least 2");
  end

  localparam int CNT_W = $clog2(timeout_cycles);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);

  localparam logic [num_bits-1:0] QNAN =
    {1'b0, {exp_width{1'b1}}, 1'b1, {(mant_width-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASSIFY,
    S_DISPATCH,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic [2:0] {
    C_ZERO,
    C_SUB,
    C_NORM,
    C_INF,
    C_QNAN,
    C_SNAN
  } fp_class_t;

  function automatic fp_class_t classify(input logic [num_bits-1:0] v);
    logic [exp_width-1:0]  e;
    logic [mant_width-1:0] m;
    fp_class_t             c;
    e = v[num_bits-2 -: exp_width];
    m = v[mant_width-1:0];
    if (&e) begin
      if (m == '0)                c = C_INF;
      else if (m[mant_width-1])   c = C_QNAN;
      else                        c = C_SNAN;
    end else if (e == '0) begin
      c = (m == '0) ? C_ZERO : C_SUB;
    end else begin
      c = C_NORM;
    end
    return c;
  endfunction

  state_t              state_q, state_d;
  logic [num_bits-1:0] a_q, a_d;
  logic [num_bits-1:0] b_q, b_d;
  logic                op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [num_bits-1:0] res_q, res_d;
  logic                inv_q, inv_d;
  logic                tmo_q, tmo_d;

  fp_class_t           cls_a, cls_b;
  logic                sign_a, sign_b;
  logic                a_inf, b_inf, a_zero, b_zero;
  logic                spec_hit;
  logic [num_bits-1:0] spec_res;
  logic                spec_inv;

  assign cls_a  = classify(a_q);
  assign cls_b  = classify(b_q);
  assign sign_a = a_q[num_bits-1];
  assign sign_b = b_q[num_bits-1];
  assign a_inf  = (cls_a == C_INF);
  assign b_inf  = (cls_b == C_INF);
  assign a_zero = (cls_a == C_ZERO);
  assign b_zero = (cls_b == C_ZERO);

  // Priority-ordered special-case table; anything unmatched goes to the core.
  always_comb begin
    spec_hit = 1'b1;
    spec_res = QNAN;
    spec_inv = 1'b0;
    if (cls_a == C_SNAN || cls_b == C_SNAN) begin
      spec_inv = 1'b1;
    end else if (cls_a == C_QNAN || cls_b == C_QNAN) begin
      spec_inv = 1'b0;
    end else if (!op_q) begin
      if (a_inf && b_inf && (sign_a != sign_b)) begin
        spec_inv = 1'b1;
      end else if (a_inf) begin
        spec_res = a_q;
      end else if (b_inf) begin
        spec_res = b_q;
      end else if (a_zero && b_zero) begin
        spec_res = {sign_a & sign_b, {(num_bits-1){1'b0}}};
      end else if (a_zero) begin
        spec_res = b_q;
      end else if (b_zero) begin
        spec_res = a_q;
      end else begin
        spec_hit = 1'b0;
      end
    end else begin
      if ((a_inf && b_zero) || (b_inf && a_zero)) begin
        spec_inv = 1'b1;
      end else if (a_inf || b_inf) begin
        spec_res = {sign_a ^ sign_b, {exp_width{1'b1}}, {mant_width{1'b0}}};
      end else if (a_zero || b_zero) begin
        spec_res = {sign_a ^ sign_b, {(num_bits-1){1'b0}}};
      end else begin
        spec_hit = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    inv_d   = inv_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          op_d    = bus.in_op;
          state_d = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        if (spec_hit) begin
          res_d   = spec_res;
          inv_d   = spec_inv;
          tmo_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (bus.core_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response arriving on the final watchdog cycle still wins.
        if (bus.core_res_valid) begin
          res_d   = bus.core_res;
          inv_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = QNAN;
          inv_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.out_ready) begin
          res_d   = '0;
          inv_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      inv_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.core_valid  = (state_q == S_DISPATCH);
  assign bus.core_a      = a_q;
  assign bus.core_b      = b_q;
  assign bus.core_op     = op_q;
  assign bus.out_valid   = (state_q == S_RESP);
  assign bus.out_res     = res_q;
  assign bus.out_invalid = inv_q;
  assign bus.out_timeout = tmo_q;

endmodule

// File: tb/tb_fp_special_case_sequencer.sv
// Directed bench for fp_special_case_sequencer: rule-level result model plus per-cycle
// scoreboard compare of the output channel, with handshake/latency checks in the driver.
module tb_fp_special_case_sequencer;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic clk;
  logic rst_n;

  fp_special_case_sequencer_if #(.num_bits(32)) bus();

  fp_special_case_sequencer #(
    .num_bits(32), .exp_width(8), .mant_width(23), .timeout_cycles(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] res;
    logic        inv;
    logic        tmo;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic        inv;
  } vec_t;
  vec_t vecs [0:13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {special, invalid, result} straight from the IEEE special-case rules.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic sa, sb, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;
    sa     = a[31];
    sb     = b[31];
    nan_a  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nan_b  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    snan_a = nan_a && !a[22];
    snan_b = nan_b && !b[22];
    inf_a  = (a[30:0] == 31'h7F800000);
    inf_b  = (b[30:0] == 31'h7F800000);
    zero_a = (a[30:0] == 31'd0);
    zero_b = (b[30:0] == 31'd0);
    if (snan_a || snan_b) return {1'b1, 1'b1, QNAN};
    if (nan_a || nan_b)   return {1'b1, 1'b0, QNAN};
    if (!op) begin
      if (inf_a && inf_b) return (sa != sb) ? {1'b1, 1'b1, QNAN} : {1'b1, 1'b0, a};
      if (inf_a)  return {1'b1, 1'b0, a};
      if (inf_b)  return {1'b1, 1'b0, b};
      if (zero_a && zero_b) return {1'b1, 1'b0, sa & sb, 31'd0};
      if (zero_a) return {1'b1, 1'b0, b};
      if (zero_b) return {1'b1, 1'b0, a};
    end else begin
      if ((inf_a && zero_b) || (inf_b && zero_a)) return {1'b1, 1'b1, QNAN};
      if (inf_a || inf_b)   return {1'b1, 1'b0, sa ^ sb, 31'h7F800000};
      if (zero_a || zero_b) return {1'b1, 1'b0, sa ^ sb, 31'd0};
    end
    return 34'd0;
  endfunction

  // Output channel compare: every cycle while a result is expected and presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() == 0) begin
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      end else if (bus.out_valid) begin
        check("out_res",     bus.out_res,              exp_q[0].res);
        check("out_invalid", 32'(bus.out_invalid),     32'(exp_q[0].inv));
        check("out_timeout", 32'(bus.out_timeout),     32'(exp_q[0].tmo));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op);
    int g;
    @(posedge clk); #1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("accept_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_in_ready",  32'(bus.in_ready),  32'd0);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rdy_cycle_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("post_in_ready",  32'(bus.in_ready),  32'd1);
    check("post_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic special_txn(input logic [31:0] a, input logic [31:0] b, input logic op, input int hold);
    logic [33:0] m;
    exp_t e;
    m = model(a, b, op);
    e.res = m[31:0];
    e.inv = m[32];
    e.tmo = 1'b0;
    exp_q.push_back(e);
    send(a, b, op);
    @(negedge clk);
    check("spec_cyc1_out_valid",  32'(bus.out_valid),  32'd0);
    check("spec_cyc1_core_valid", 32'(bus.core_valid), 32'd0);
    @(negedge clk);
    check("spec_cyc2_out_valid",  32'(bus.out_valid),  32'd1);
    check("spec_cyc2_core_valid", 32'(bus.core_valid), 32'd0);
    drain(hold);
  endtask

  task automatic core_txn(input logic [31:0] a, input logic [31:0] b, input logic op,
                          input int rdy_dly, input logic [31:0] resp, input int resp_dly,
                          input logic tmo, input int hold);
    logic [33:0] m;
    exp_t e;
    int waits;
    m = model(a, b, op);
    check("model_nonspecial", 32'(m[33]), 32'd0);
    e.res = tmo ? QNAN : resp;
    e.inv = 1'b0;
    e.tmo = tmo;
    exp_q.push_back(e);
    send(a, b, op);
    @(negedge clk);
    check("classify_core_valid", 32'(bus.core_valid), 32'd0);
    for (int i = 0; i <= rdy_dly; i++) begin
      @(negedge clk);
      check("dispatch_core_valid", 32'(bus.core_valid), 32'd1);
      check("dispatch_core_a",     bus.core_a,          a);
      check("dispatch_core_b",     bus.core_b,          b);
      check("dispatch_core_op",    32'(bus.core_op),    32'(op));
      if (i == rdy_dly) bus.core_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.core_ready = 1'b0;
    @(negedge clk);
    check("wait_core_valid", 32'(bus.core_valid), 32'd0);
    check("wait_out_valid",  32'(bus.out_valid),  32'd0);
    if (!tmo) begin
      for (int k = 0; k < resp_dly; k++) begin
        @(negedge clk);
        check("wait_out_valid", 32'(bus.out_valid), 32'd0);
      end
      bus.core_res       = resp;
      bus.core_res_valid = 1'b1;
      @(posedge clk); #1;
      bus.core_res_valid = 1'b0;
      bus.core_res       = 32'd0;
      @(negedge clk);
      check("core_resp_latency", 32'(bus.out_valid), 32'd1);
    end else begin
      waits = 1;
      @(negedge clk);
      while (!bus.out_valid && waits < 100) begin
        waits++;
        @(negedge clk);
      end
      check("timeout_wait_cycles", 32'(waits), 32'd8);
    end
    drain(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b1};
    vecs[1]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b1};
    vecs[2]  = '{32'hFF800000, 32'h40000000, 1'b1, 32'hFF800000, 1'b0};
    vecs[3]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0};
    vecs[4]  = '{32'h00000000, 32'hC0400000, 1'b1, 32'h80000000, 1'b0};
    vecs[5]  = '{32'h00000000, 32'h00000001, 1'b0, 32'h00000001, 1'b0};
    vecs[6]  = '{32'hFFC00000, 32'h3F800000, 1'b1, 32'h7FC00000, 1'b0};
    vecs[7]  = '{32'h7F800000, 32'h80000000, 1'b1, 32'h7FC00000, 1'b1};
    vecs[8]  = '{32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 1'b0};
    vecs[9]  = '{32'h40490FDB, 32'h80000000, 1'b0, 32'h40490FDB, 1'b0};
    vecs[10] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0};
    vecs[11] = '{32'h7FC00000, 32'h7F800001, 1'b1, 32'h7FC00000, 1'b1};
    vecs[12] = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 1'b0};
    vecs[13] = '{32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0};

    bus.in_valid       = 1'b0;
    bus.in_a           = 32'd0;
    bus.in_b           = 32'd0;
    bus.in_op          = 1'b0;
    bus.core_ready     = 1'b0;
    bus.core_res_valid = 1'b0;
    bus.core_res       = 32'd0;
    bus.out_ready      = 1'b0;
    rst_n              = 1'b0;

    #1;
    check("rst_in_ready",    32'(bus.in_ready),    32'd1);
    check("rst_out_valid",   32'(bus.out_valid),   32'd0);
    check("rst_core_valid",  32'(bus.core_valid),  32'd0);
    check("rst_out_res",     bus.out_res,          32'd0);
    check("rst_out_invalid", 32'(bus.out_invalid), 32'd0);
    check("rst_out_timeout", 32'(bus.out_timeout), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Special-case pairs: pin the model to hand values, then run each through the DUT.
    for (int i = 0; i < 14; i++) begin
      logic [33:0] m;
      m = model(vecs[i].a, vecs[i].b, vecs[i].op);
      check($sformatf("model_special_%0d", i), 32'(m[33]), 32'd1);
      check($sformatf("model_res_%0d", i),     m[31:0],    vecs[i].res);
      check($sformatf("model_inv_%0d", i),     32'(m[32]), 32'(vecs[i].inv));
      special_txn(vecs[i].a, vecs[i].b, vecs[i].op, i % 3);
    end

    // 1.5 * 2.0 via the core, slow dispatch accept and slow consumer.
    core_txn(32'h3FC00000, 32'h40000000, 1'b1, 3, 32'h40400000, 1, 1'b0, 2);
    // Subnormal + normal goes to the core; response lands on the final watchdog cycle.
    core_txn(32'h00000001, 32'h3F800000, 1'b0, 0, 32'h3F800000, 7, 1'b0, 0);
    // Core never answers.
    core_txn(32'h3F800000, 32'h40000000, 1'b0, 0, 32'd0, 0, 1'b1, 1);

    bus.core_res       = 32'h12345678;
    bus.core_res_valid = 1'b1;
    @(posedge clk); #1;
    bus.core_res_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stray_resp_out_valid", 32'(bus.out_valid), 32'd0);
    end

    // Reset while waiting on the core.
    send(32'h3FC00000, 32'h40000000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("rtest_core_valid", 32'(bus.core_valid), 32'd1);
    bus.core_ready = 1'b1;
    @(posedge clk); #1;
    bus.core_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",    32'(bus.in_ready),    32'd1);
    check("mid_rst_out_valid",   32'(bus.out_valid),   32'd0);
    check("mid_rst_core_valid",  32'(bus.core_valid),  32'd0);
    check("mid_rst_out_res",     bus.out_res,          32'd0);
    check("mid_rst_out_invalid", 32'(bus.out_invalid), 32'd0);
    check("mid_rst_out_timeout", 32'(bus.out_timeout), 32'd0);
    check("mid_rst_core_a",      bus.core_a,           32'd0);
    check("mid_rst_core_b",      bus.core_b,           32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    bus.core_res       = 32'h40400000;
    bus.core_res_valid = 1'b1;
    @(posedge clk); #1;
    bus.core_res_valid = 1'b0;
    bus.core_res       = 32'd0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
    end

    // 2.0 * 3.0 = 6.0, then one more special pair.
    core_txn(32'h40000000, 32'h40400000, 1'b1, 1, 32'h40C00000, 2, 1'b0, 0);
    special_txn(32'h7F800001, 32'h3F800000, 1'b0, 0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
